// File: rtl/if_prefetch_unit.sv
// Instruction fetch stage: owns the fetch PC, issues 1-cycle-latency reads and queues tagged words for decode.
// Define IF_BYPASS_EN to present a response arriving at an empty queue on the same cycle.
module if_prefetch_unit #(
  parameter int                ADDR_W   = 32,
  parameter int                INSTR_W  = 32,
  parameter int                OFFSET_W = 16,
  parameter int                DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic                       clk,
  input  logic                       PC_reset,
  input  logic                       PC_WE,
  input  logic                       PC_Src,
  input  logic [OFFSET_W-1:0]        offset,
  input  logic [ADDR_W-1:0]          branch_pc,
  output logic                       imem_req,
  output logic [ADDR_W-1:0]          imem_addr,
  input  logic [INSTR_W-1:0]         imem_rdata,
  output logic                       instr_valid,
  input  logic                       instr_ready,
  output logic [INSTR_W-1:0]         instruction,
  output logic [ADDR_W-1:0]          instr_pc,
  output logic [$clog2(DEPTH):0]     q_count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef struct packed {
    logic [ADDR_W-1:0]  pc;
    logic [INSTR_W-1:0] instr;
  } entry_t;

  logic [ADDR_W-1:0] fpc, tag_q, target, off_ext;
  logic              inflight;
  entry_t            mem [DEPTH];
  entry_t            head, last_q;
  logic [PW-1:0]     wr_ptr, rd_ptr;
  logic [CW-1:0]     count;
  logic [CW:0]       occ;
  logic              resp_v, bypass_v, pop_now, pop, fifo_pop, push, req, empty;
  logic              unused_bits;

  assign unused_bits = ^branch_pc[1:0];

  assign off_ext = ADDR_W'($signed(offset));
  assign target  = {branch_pc[ADDR_W-1:2], 2'b00} + ADDR_W'(4) + (off_ext << 2);

  assign empty  = (count == '0);
  assign head   = mem[rd_ptr];
  assign resp_v = inflight && !PC_Src;

`ifdef IF_BYPASS_EN
  assign bypass_v = resp_v && empty;
`else
  assign bypass_v = 1'b0;
`endif

  assign instr_valid = !empty || bypass_v;
  assign instruction = bypass_v ? imem_rdata : (!empty ? head.instr : last_q.instr);
  assign instr_pc    = bypass_v ? tag_q      : (!empty ? head.pc    : last_q.pc);
  assign q_count     = count;

  // Redirect discards a coincident pop; a bypassed word never occupies a slot.
  assign pop_now  = instr_valid && instr_ready;
  assign pop      = pop_now && !PC_Src;
  assign fifo_pop = pop && !bypass_v;
  assign push     = resp_v && !(bypass_v && instr_ready);

  // Occupancy counts the in-flight word so a full queue can never be overrun.
  assign occ       = {1'b0, count} + (CW+1)'(inflight) - (CW+1)'(pop_now);
  assign req       = !PC_reset && PC_WE && !PC_Src && (occ < (CW+1)'(DEPTH));
  assign imem_req  = req;
  assign imem_addr = fpc;

  always_ff @(posedge clk or posedge PC_reset) begin
    if (PC_reset) begin
      fpc      <= RESET_PC;
      inflight <= 1'b0;
      tag_q    <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      last_q   <= '0;
    end else if (PC_Src) begin
      fpc      <= target;
      inflight <= 1'b0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
    end else begin
      inflight <= req;
      if (req) begin
        fpc   <= fpc + ADDR_W'(4);
        tag_q <= fpc;
      end
      if (push)     wr_ptr <= wr_ptr + PW'(1);
      if (fifo_pop) rd_ptr <= rd_ptr + PW'(1);
      count <= count + CW'(push) - CW'(fifo_pop);
      if (pop) last_q <= '{pc: instr_pc, instr: instruction};
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= '{pc: tag_q, instr: imem_rdata};
  end

endmodule

// File: tb/tb_if_prefetch_unit.sv
// Directed bench for if_prefetch_unit: expected PCs queued by stimulus, delivered words checked by a monitor.
module tb_if_prefetch_unit;
  logic        clk = 1'b0;
  logic        PC_reset, PC_WE, PC_Src, instr_ready;
  logic [15:0] offset;
  logic [31:0] branch_pc, imem_rdata, imem_addr, instruction, instr_pc;
  logic        imem_req, instr_valid;
  logic [2:0]  q_count;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];

`ifdef IF_BYPASS_EN
  localparam logic BYP = 1'b1;
`else
  localparam logic BYP = 1'b0;
`endif

  if_prefetch_unit dut (
    .clk(clk), .PC_reset(PC_reset), .PC_WE(PC_WE), .PC_Src(PC_Src),
    .offset(offset), .branch_pc(branch_pc), .imem_req(imem_req),
    .imem_addr(imem_addr), .imem_rdata(imem_rdata), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .instruction(instruction), .instr_pc(instr_pc),
    .q_count(q_count)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(logic [31:0] a);
    return {a[15:0] ^ 16'h5A5A, ~a[15:0]};
  endfunction

  // Instruction memory: data valid the cycle after the request.
  initial imem_rdata = '0;
  always @(posedge clk) if (imem_req) imem_rdata <= mem_word(imem_addr);

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (!PC_reset && instr_valid && instr_ready && !PC_Src) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_word got pc %0h expected none", instr_pc);
      end else begin
        logic [31:0] e;
        e = exp_q.pop_front();
        chk("deliv_pc", instr_pc, e);
        chk("deliv_instr", instruction, mem_word(e));
      end
    end
  end

  initial begin
    PC_reset = 1'b1; PC_WE = 1'b1; PC_Src = 1'b0; instr_ready = 1'b1;
    offset = '0; branch_pc = '0;
    #3;
    chk("rst_req", imem_req, 0);
    chk("rst_addr", imem_addr, 0);
    chk("rst_valid", instr_valid, 0);
    chk("rst_instr", instruction, 0);
    chk("rst_pc", instr_pc, 0);
    chk("rst_qcount", q_count, 0);

    // Streaming from reset: six sequential fetches.
    #7 PC_reset = 1'b0;
    for (int k = 0; k < 6; k++) exp_q.push_back(32'(4 * k));
    #3;
    chk("s_req0", imem_req, 1);
    chk("s_addr0", imem_addr, 0);
    chk("s_valid0", instr_valid, 0);
    for (int k = 1; k < 6; k++) begin
      tick(); #2;
      chk("s_req", imem_req, 1);
      chk("s_addr", imem_addr, 32'(4 * k));
      if (k == 1) chk("s_latency", instr_valid, BYP);
      if (k == 2) chk("s_valid2", instr_valid, 1);
    end
    tick(); PC_WE = 1'b0;
    repeat (6) tick();
    #2;
    chk("s_drain_q", q_count, 0);
    chk("s_empty_valid", instr_valid, 0);
    chk("s_hold_pc", instr_pc, 32'h14);
    chk("s_hold_instr", instruction, mem_word(32'h14));
    chk("s_exp_left", exp_q.size(), 0);

    // Backpressure: queue fills to DEPTH, then drains in order.
    for (int k = 0; k < 5; k++) exp_q.push_back(32'(24 + 4 * k));
    tick(); instr_ready = 1'b0; PC_WE = 1'b1;
    repeat (8) tick();
    #2;
    chk("bp_full", q_count, 4);
    chk("bp_noreq", imem_req, 0);
    chk("bp_valid", instr_valid, 1);
    chk("bp_head", instr_pc, 32'd24);
    tick(); instr_ready = 1'b1;
    #2;
    chk("bp_resume_req", imem_req, 1);
    chk("bp_resume_addr", imem_addr, 32'd40);
    tick(); PC_WE = 1'b0;
    repeat (8) tick();
    #2;
    chk("bp_drain_q", q_count, 0);
    chk("bp_exp_left", exp_q.size(), 0);

    // Redirect with two queued and one in flight: target 0x10+4-8 = 0x0C.
    tick(); instr_ready = 1'b0; PC_WE = 1'b1;
    tick(); tick();
    tick(); PC_Src = 1'b1; branch_pc = 32'h10; offset = 16'hFFFE;
    #2;
    chk("rd_q_before", q_count, 2);
    chk("rd_noreq", imem_req, 0);
    tick(); PC_Src = 1'b0;
    exp_q.push_back(32'h0C);
    #2;
    chk("rd_flushed", q_count, 0);
    chk("rd_valid", instr_valid, 0);
    chk("rd_req", imem_req, 1);
    chk("rd_target", imem_addr, 32'h0C);
    tick(); PC_WE = 1'b0;
    tick(); tick();
    #2;
    chk("rd_q_after", q_count, 1);
    chk("rd_head", instr_pc, 32'h0C);
    tick(); instr_ready = 1'b1;
    repeat (4) tick();
    #2;
    chk("rd_exp_left", exp_q.size(), 0);

    // Redirect coinciding with a pop, targeting near the top of the address space.
    tick(); instr_ready = 1'b0; PC_WE = 1'b1;
    repeat (7) tick();
    #2;
    chk("rp_full", q_count, 4);
    tick(); instr_ready = 1'b1; PC_Src = 1'b1; branch_pc = 32'hFFFF_FFF0; offset = 16'h0001;
    #2;
    chk("rp_valid_pre", instr_valid, 1);
    chk("rp_head_pre", instr_pc, 32'h10);
    tick(); PC_Src = 1'b0;
    exp_q.push_back(32'hFFFF_FFF8);
    exp_q.push_back(32'hFFFF_FFFC);
    exp_q.push_back(32'h0);
    #2;
    chk("rp_valid_post", instr_valid, 0);
    chk("rp_q_post", q_count, 0);
    chk("wrap_addr0", imem_addr, 32'hFFFF_FFF8);
    tick(); #2;
    chk("wrap_addr1", imem_addr, 32'hFFFF_FFFC);
    tick(); #2;
    chk("wrap_addr2", imem_addr, 32'h0);
    tick(); PC_WE = 1'b0;
    repeat (5) tick();
    #2;
    chk("rp_exp_left", exp_q.size(), 0);

    // Asynchronous reset with three words queued.
    tick(); instr_ready = 1'b0; PC_WE = 1'b1;
    tick(); tick();
    tick(); PC_WE = 1'b0;
    tick(); tick();
    #2;
    chk("ar_q_before", q_count, 3);
    #3 PC_reset = 1'b1;
    #1;
    chk("ar_q", q_count, 0);
    chk("ar_valid", instr_valid, 0);
    chk("ar_req", imem_req, 0);
    chk("ar_addr", imem_addr, 0);
    chk("ar_pc", instr_pc, 0);
    chk("ar_instr", instruction, 0);
    tick(); PC_reset = 1'b0; instr_ready = 1'b1; PC_WE = 1'b1;
    exp_q.push_back(32'h0);
    exp_q.push_back(32'h4);
    #2;
    chk("ar_restart_req", imem_req, 1);
    chk("ar_restart_addr", imem_addr, 0);
    tick(); tick(); PC_WE = 1'b0;
    repeat (5) tick();
    #2;
    chk("ar_exp_left", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
